// File: rtl/score_sched.sv
// Scoreboard command scheduler: edge-detects keypad levels, round-robins them against a button
// channel and applies one saturating score update per cycle. Optional undo: SCORE_UNDO_EN.
module score_sched #(
  parameter int unsigned SCORE_W   = 8,
  parameter int unsigned MAX_SCORE = 199
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               plus1_G,
  input  logic               plus2_G,
  input  logic               plus3_G,
  input  logic               minus1_G,
  input  logic               minus2_G,
  input  logic               minus3_G,
  input  logic               plus1_H,
  input  logic               plus2_H,
  input  logic               plus3_H,
  input  logic               minus1_H,
  input  logic               minus2_H,
  input  logic               minus3_H,
  input  logic               pause,
  input  logic               btn_req,
  input  logic               btn_team,
  input  logic               btn_sub,
  input  logic [1:0]         btn_amt,
  input  logic               undo,
  output logic               btn_ack,
  output logic [SCORE_W-1:0] score_G,
  output logic [SCORE_W-1:0] score_H,
  output logic               running,
  output logic               sat,
  output logic               busy
);

  localparam int unsigned NK = 12;
  localparam logic LAST_KEY = 1'b0;
  localparam logic LAST_BTN = 1'b1;
  localparam logic [SCORE_W:0] MAX_W = MAX_SCORE[SCORE_W:0];

  logic [NK:0]        key_in, key_r, key_q, rise;
  logic [NK-1:0]      pend_q, pend_d, clr;
  logic [3:0]         key_sel, key_loc;
  logic               key_team, key_sub;
  logic [1:0]         key_amt;
  logic               btn_req_r, btn_team_r, btn_sub_r;
  logic [1:0]         btn_amt_r;
  logic               last_q, key_work, btn_work, grant_key, grant_btn, stall;
  logic               do_upd, op_team, op_sub, clip;
  logic [1:0]         op_amt;
  logic               undo_team, undo_sub;
  logic [1:0]         undo_amt;
  logic [SCORE_W:0]   old_w, amt_w, new_w;
  logic               ack_q, sat_q, running_q;
  logic [SCORE_W-1:0] score_g_q, score_h_q;

  assign key_in = {pause, minus3_H, minus2_H, minus1_H, plus3_H, plus2_H, plus1_H,
                   minus3_G, minus2_G, minus1_G, plus3_G, plus2_G, plus1_G};
  assign rise   = key_r & ~key_q;

  // Lowest pending index has priority.
  always_comb begin
    key_sel = '0;
    for (int i = NK - 1; i >= 0; i--) begin
      if (pend_q[i]) key_sel = 4'(i);
    end
  end

  assign key_team = (key_sel >= 4'd6);
  assign key_loc  = key_team ? key_sel - 4'd6 : key_sel;
  assign key_sub  = (key_loc >= 4'd3);

  always_comb begin
    case (key_loc)
      4'd0, 4'd3: key_amt = 2'd1;
      4'd1, 4'd4: key_amt = 2'd2;
      4'd2, 4'd5: key_amt = 2'd3;
      default:    key_amt = 2'd0;
    endcase
  end

  // The ack cycle masks the still-registered request so one handshake yields one update.
  assign key_work  = |pend_q;
  assign btn_work  = btn_req_r & ~ack_q;
  assign grant_key = ~stall & key_work & (~btn_work | (last_q == LAST_BTN));
  assign grant_btn = ~stall & btn_work & (~key_work | (last_q == LAST_KEY));

  assign clr    = grant_key ? (NK'(1) << key_sel) : '0;
  assign pend_d = (pend_q & ~clr) | rise[NK-1:0];

  always_comb begin
    do_upd  = 1'b1;
    op_team = 1'b0;
    op_sub  = 1'b0;
    op_amt  = 2'd0;
    if (stall) begin
      op_team = undo_team;
      op_sub  = undo_sub;
      op_amt  = undo_amt;
    end else if (grant_key) begin
      op_team = key_team;
      op_sub  = key_sub;
      op_amt  = key_amt;
    end else if (grant_btn) begin
      op_team = btn_team_r;
      op_sub  = btn_sub_r;
      op_amt  = btn_amt_r;
    end else begin
      do_upd  = 1'b0;
    end
  end

  assign old_w = {1'b0, (op_team ? score_h_q : score_g_q)};
  assign amt_w = {{(SCORE_W - 1){1'b0}}, op_amt};

  always_comb begin
    clip  = 1'b0;
    new_w = old_w + amt_w;
    if (op_sub) begin
      if (old_w < amt_w) begin
        clip  = 1'b1;
        new_w = '0;
      end else begin
        new_w = old_w - amt_w;
      end
    end else if (new_w > MAX_W) begin
      clip  = 1'b1;
      new_w = MAX_W;
    end
  end

`ifdef SCORE_UNDO_EN
  logic       undo_r, undo_q, hist_vld_q, hist_team_q, hist_sub_q;
  logic [1:0] hist_amt_q;

  assign stall     = undo_r & ~undo_q & hist_vld_q;
  assign undo_team = hist_team_q;
  assign undo_sub  = ~hist_sub_q;
  assign undo_amt  = hist_amt_q;

  // History holds the post-saturation change, so reversing it can never clip.
  always_ff @(posedge clk) begin
    if (reset) begin
      undo_r      <= undo;
      undo_q      <= undo;
      hist_vld_q  <= 1'b0;
      hist_team_q <= 1'b0;
      hist_sub_q  <= 1'b0;
      hist_amt_q  <= 2'd0;
    end else begin
      undo_r <= undo;
      undo_q <= undo_r;
      if (stall) begin
        hist_vld_q <= 1'b0;
      end else if (do_upd) begin
        hist_vld_q  <= 1'b1;
        hist_team_q <= op_team;
        hist_sub_q  <= op_sub;
        hist_amt_q  <= 2'(op_sub ? old_w - new_w : new_w - old_w);
      end
    end
  end
`else
  logic unused_undo;
  assign unused_undo = undo;
  assign stall       = 1'b0;
  assign undo_team   = 1'b0;
  assign undo_sub    = 1'b0;
  assign undo_amt    = 2'd0;
`endif

  // Edge registers load the live inputs in reset so keys held through it never fire.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_r      <= key_in;
      key_q      <= key_in;
      pend_q     <= '0;
      btn_req_r  <= 1'b0;
      btn_team_r <= 1'b0;
      btn_sub_r  <= 1'b0;
      btn_amt_r  <= 2'd0;
      last_q     <= LAST_BTN;
      running_q  <= 1'b0;
      sat_q      <= 1'b0;
      ack_q      <= 1'b0;
      score_g_q  <= '0;
      score_h_q  <= '0;
    end else begin
      key_r      <= key_in;
      key_q      <= key_r;
      pend_q     <= pend_d;
      btn_req_r  <= btn_req;
      btn_team_r <= btn_team;
      btn_sub_r  <= btn_sub;
      btn_amt_r  <= btn_amt;
      if (grant_key) begin
        last_q <= LAST_KEY;
      end else if (grant_btn) begin
        last_q <= LAST_BTN;
      end
      if (rise[NK]) running_q <= ~running_q;
      sat_q <= do_upd & clip;
      ack_q <= grant_btn;
      if (do_upd) begin
        if (op_team) score_h_q <= new_w[SCORE_W-1:0];
        else         score_g_q <= new_w[SCORE_W-1:0];
      end
    end
  end

  assign score_G = score_g_q;
  assign score_H = score_h_q;
  assign running = running_q;
  assign sat     = sat_q;
  assign btn_ack = ack_q;
  assign busy    = key_work | btn_req;

endmodule

// File: doc/score_sched.md
# score_sched

Command scheduler between the PS/2 key decoder and the scoreboard score registers. It edge-detects the decoder's plus/minus/pause level outputs, buffers them as pending commands, and arbitrates them round-robin against a push-button request channel. It applies exactly one saturating score update per cycle to the Guest and Home score registers. The pause key drives the game-clock run flag.

## Interface

Parameters:
- `SCORE_W`, default 8: width of each score register.
- `MAX_SCORE`, default 199: saturation ceiling; must be below 2^SCORE_W.

Ports:
- `clk`, in, 1: the single clock.
- `reset`, in, 1: synchronous reset, active-high.
- `plus1_G`, `plus2_G`, `plus3_G`, `minus1_G`, `minus2_G`, `minus3_G`, in, 1 each: Guest key levels from the decoder.
- `plus1_H`, `plus2_H`, `plus3_H`, `minus1_H`, `minus2_H`, `minus3_H`, in, 1 each: Home key levels from the decoder.
- `pause`, in, 1: pause key level.
- `btn_req`, in, 1: button command request.
- `btn_team`, in, 1: 0 selects Guest, 1 selects Home.
- `btn_sub`, in, 1: 0 adds, 1 subtracts.
- `btn_amt`, in, 2: magnitude 1–3; 0 is a no-op command, still acked.
- `undo`, in, 1: undo request; level, rising-edge active.
- `btn_ack`, out, 1: one-cycle pulse when the button command is applied.
- `score_G`, out, SCORE_W: Guest score.
- `score_H`, out, SCORE_W: Home score.
- `running`, out, 1: game clock run flag.
- `sat`, out, 1: one-cycle pulse when the applied update was clipped.
- `busy`, out, 1: high when any key command is pending or `btn_req` is high.

## Operation

- **Edge detection:** all 13 key inputs are registered each cycle. Rise = `in & ~in_q`.
- **Pending register:** 12 bits, one per plus/minus key. A rise sets its bit. A bit clears when that command is granted.
  - A rise on an already-set bit is coalesced, so it is lost.
  - A rise and a clear on the same bit in the same cycle leaves the bit set.
- **Key priority:** lowest index wins, in the order plus1_G, plus2_G, plus3_G, minus1_G, minus2_G, minus3_G, then the same six for H.
- **Arbiter:** at most one grant per cycle.
  - Only one source has work: that source wins.
  - Both have work: the source not granted last time wins.
  - The `last` register resets to "button", so the keyboard wins the first tie.
- **Execute:** for the granted team, apply `new = old + amt` or `old - amt`.
  - Add result above MAX_SCORE: store MAX_SCORE and pulse `sat`.
  - Subtract result below 0: store 0 and pulse `sat`.
  - Arithmetic uses SCORE_W+1 bits internally, so wrap-around never occurs.
- **Button handshake:**
  - The requester holds `btn_req`, `btn_team`, `btn_sub` and `btn_amt` stable until `btn_ack`.
  - The requester deasserts `btn_req` in the cycle after `btn_ack`.
  - If `btn_req` is still high that cycle, it is a new command.
- **Pause:** a rise on `pause` toggles `running`. It is independent of the arbiter and never blocks score updates.
- **Reset mid-operation:** clears the pending bits, edge registers, scores, `running` and undo history. A held `btn_req` is re-arbitrated from scratch. Keys held through reset produce no rise until they are released and pressed again.

## Timing

- **Reset values:** `score_G`=0, `score_H`=0, `running`=0, `sat`=0, `btn_ack`=0, `busy`=0 (follows `btn_req` combinationally after reset); `last`=button.
- **Key latency:**
  - Key first sampled high at edge n.
  - Pending bit set at edge n+1.
  - Score updated at edge n+2 if uncontended.
- **Button latency:** `btn_req` sampled high at edge n. If granted, the score updates and `btn_ack`=1 at edge n+1.
- **Pulse alignment:** `sat` and `btn_ack` are registered and share a cycle with the score change they describe.
- **Throughput:** one update per cycle. Six simultaneous key rises drain in six consecutive cycles.
- **`running` latency:** changes at edge n+1 after a pause rise is sampled at edge n.

## Configuration

- **Macro:** `SCORE_UNDO_EN`.
- **Defined:**
  - A one-deep history register stores the team and the applied signed change, which is the post-saturation difference.
  - An `undo` rise applies the inverse change in the next cycle. In that cycle it takes priority over both sources; they stall one cycle and keep their state.
  - The history is invalidated after an undo and after reset, so a second undo is a no-op.
  - An undo never saturates, because it reverses an actual change.
- **Undefined:** the `undo` port exists but is ignored, and no history logic is built.

## Test plan

- **Basic key:** reset, then hold `plus3_H` high for 5 cycles → `score_H`=3 two cycles after the rise; it does not increment again while held.
- **Simultaneous keys:** `plus1_G`, `plus2_G` and `minus1_H` rise together with `score_H`=0 → `score_G`=1 then 3 on consecutive cycles; `score_H` stays 0 with a `sat` pulse on the third cycle.
- **Contention:** `plus2_G` pending with `btn_req` (H, +3) held, reset fresh → keyboard granted first, then the button: `score_G`=2, then `score_H`=3 with `btn_ack`; drop `btn_req` after the ack and no further update occurs.
- **Ceiling:** `score_G`=198, `plus3_G` → `score_G`=199 and `sat`=1 for one cycle; a further `plus1_G` → 199, `sat`=1.
- **Pause and reset:** two `pause` rises → `running` goes 0→1→0; assert `reset` with a key pending → scores 0 and no update after reset is released.
- **Undo (`SCORE_UNDO_EN` only):** `score_H`=198, `plus3_H` → 199; `undo` → 198; second `undo` → 198 unchanged.
